// File: rtl/i2c_pkg.sv
// Shared types and constants for the i2c master arbiter.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StRespond
    } arb_state_e;

    localparam int unsigned WdogWidth      = 20;
    localparam logic [19:0] TimeoutDefault = 20'hFFFFF;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches from last_grant+1 upward (mod NUM_REQ), one-hot result.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((32'(last_grant) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c master among NUM_REQ requesters, one latched transaction at a time,
// with a watchdog covering the master's busy/done handshake.
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_BYTES = 1,
    parameter int unsigned DATA_BYTES = 2,
    parameter int unsigned ST_WIDTH   = 1 + ADDR_BYTES + DATA_BYTES,
    parameter logic [19:0] TIMEOUT    = TimeoutDefault
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_read,
    input  logic [7*NUM_REQ-1:0]             req_chip_addr,
    input  logic [8*ADDR_BYTES*NUM_REQ-1:0]  req_reg_addr,
    input  logic [8*DATA_BYTES*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [8*DATA_BYTES-1:0]          rsp_rdata,
    output logic                             rsp_nack,
    output logic                             rsp_timeout,
    output logic [6:0]                       m_chip_addr,
    output logic [8*ADDR_BYTES-1:0]          m_reg_addr,
    output logic [8*DATA_BYTES-1:0]          m_data_in,
    output logic                             m_write_en,
    output logic                             m_read_en,
    output logic                             m_write_mode,
    input  logic [8*DATA_BYTES-1:0]          m_data_out,
    input  logic [ST_WIDTH-1:0]              m_status,
    input  logic                             m_done,
    input  logic                             m_busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned AW    = 8 * ADDR_BYTES;
    localparam int unsigned DW    = 8 * DATA_BYTES;

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [6:0]           chip_q, chip_d;
    logic [AW-1:0]        reg_q, reg_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic                 read_q, read_d;
    logic [WdogWidth-1:0] wdog_q, wdog_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic                 nack_q, nack_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_REQ-1:0]   rr_grant;
    logic [IDX_W-1:0]     sel_idx;
    logic [6:0]           sel_chip;
    logic [AW-1:0]        sel_reg;
    logic [DW-1:0]        sel_wdata;
    logic                 sel_read;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req       (req),
        .last_grant(last_grant_q),
        .grant     (rr_grant)
    );

    // Demux the flattened request fields of the winning requester.
    always_comb begin
        sel_idx   = '0;
        sel_chip  = '0;
        sel_reg   = '0;
        sel_wdata = '0;
        sel_read  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rr_grant[i]) begin
                sel_idx   = IDX_W'(i);
                sel_chip  = req_chip_addr[7*i +: 7];
                sel_reg   = req_reg_addr[AW*i +: AW];
                sel_wdata = req_wdata[DW*i +: DW];
                sel_read  = req_read[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        grant_d      = grant_q;
        chip_d       = chip_q;
        reg_d        = reg_q;
        wdata_d      = wdata_q;
        read_d       = read_q;
        wdog_d       = wdog_q;
        rdata_d      = rdata_q;
        nack_d       = nack_q;
        timeout_d    = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StIssue;
                    grant_d = rr_grant;
                    idx_d   = sel_idx;
                    chip_d  = sel_chip;
                    reg_d   = sel_reg;
                    wdata_d = sel_wdata;
                    read_d  = sel_read;
                end
            end
            StIssue: begin
                wdog_d  = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                wdog_d = wdog_q + 20'd1;
                if (m_busy) begin
                    state_d = StWaitDone;
                end else if (wdog_d == TIMEOUT) begin
                    state_d   = StRespond;
                    nack_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            StWaitDone: begin
                wdog_d = wdog_q + 20'd1;
                if (m_done) begin
                    state_d   = StRespond;
                    rdata_d   = m_data_out;
                    nack_d    = |m_status;
                    timeout_d = 1'b0;
                end else if (wdog_d == TIMEOUT) begin
                    // Read data from the previous transaction is deliberately kept.
                    state_d   = StRespond;
                    nack_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            StRespond: begin
                state_d      = StIdle;
                grant_d      = '0;
                last_grant_d = idx_q;
                wdog_d       = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            idx_q        <= '0;
            grant_q      <= '0;
            chip_q       <= '0;
            reg_q        <= '0;
            wdata_q      <= '0;
            read_q       <= 1'b0;
            wdog_q       <= '0;
            rdata_q      <= '0;
            nack_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            grant_q      <= grant_d;
            chip_q       <= chip_d;
            reg_q        <= reg_d;
            wdata_q      <= wdata_d;
            read_q       <= read_d;
            wdog_q       <= wdog_d;
            rdata_q      <= rdata_d;
            nack_q       <= nack_d;
            timeout_q    <= timeout_d;
        end
    end

    assign grant        = grant_q;
    assign rsp_valid    = (state_q == StRespond) ? grant_q : '0;
    assign rsp_rdata    = rdata_q;
    assign rsp_nack     = nack_q;
    assign rsp_timeout  = timeout_q;
    assign m_chip_addr  = chip_q;
    assign m_reg_addr   = reg_q;
    assign m_data_in    = wdata_q;
    assign m_write_en   = (state_q == StIssue) && !read_q;
    assign m_read_en    = (state_q == StIssue) && read_q;
    assign m_write_mode = 1'b0;

endmodule
